semaforo_multi: RTL
===================

Name: semaforo_multi

Overview:
Parametrised successor of the two-way traffic-light controller. Sequences NUM_PH signal phases round-robin, each through GREEN -> YELLOW -> ALL-RED, with per-state durations set by parameters. Per-phase demand inputs are latched, and each latched demand is acknowledged when its phase turns green. An actuated mode skips phases with no demand and rests in green when there is no other demand.

Parameters:
NUM_PH, 2, number of phases/approaches (2..8)
CNT_W, 9, dwell counter width; elaboration error if any T_* > 2**CNT_W-1
T_GREEN, 20, green dwell in clk cycles (>=1)
T_YELLOW, 4, yellow dwell in clk cycles (>=1)
T_ALLRED, 2, all-red clearance in clk cycles (>=1)
ACTUATED, 0, 0 = fixed cycle through all phases; 1 = demand-actuated skip/rest

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  synchronous, active-high reset
req  in  NUM_PH  per-phase demand (button/detector), level sampled each clk
lights  out  3*NUM_PH  phase i at [3i+2:3i]; 100 green, 010 yellow, 001 red
phase  out  $clog2(NUM_PH) (min 1)  index of phase currently owning green/yellow/clearance
served  out  NUM_PH  one-cycle pulse on bit i in the first GREEN cycle of phase i when pend[i] was set
pend  out  NUM_PH  latched, not-yet-served demands

Behaviour:
- Reset (rst=1 at posedge): state=GREEN, phase=0, cnt=1, pend=0, served=0. lights = phase 0 100, all others 001. Outputs are registered and valid the cycle after reset.
- FSM states: GREEN, YELLOW, ALLRED (plus FLASH, see Optional Feature). cnt counts 1..T within a state and resets to 1 on every state change.
- Each state lasts exactly T_GREEN, T_YELLOW or T_ALLRED cycles.
- GREEN -> YELLOW -> ALLRED -> GREEN of the next phase.
- In ALLRED every phase shows 001. Non-active phases show 001 in all states.
- Fixed mode (ACTUATED=0): next phase = (phase+1) mod NUM_PH, unconditionally.
- Actuated mode (ACTUATED=1):
  - At the end of GREEN: if no pend bit other than the current phase is set, hold GREEN with cnt saturated at T_GREEN (rest).
  - Leave rest in the cycle after any other pend bit sets: YELLOW starts on the next posedge.
  - At the end of ALLRED: next phase = first index with pend set, searching upward from phase+1 with wrap-around. If none is set (cannot normally occur), use phase+1.
- Demand latch: pend[i] is set when req[i]=1, except that req[i] is ignored while phase i is in GREEN.
  - pend[i] clears on entry to GREEN of phase i; served[i] pulses in that same cycle.
  - Same-cycle set and clear for the same bit: clear wins.
- Wrap: phase NUM_PH-1 -> 0. With NUM_PH=2 this reduces to alternating A/B.
- Reset mid-cycle: immediate return to reset values on the next posedge; pending demands are discarded.
- Exactly one phase is non-red at any time.

Optional Feature:
Macro SEMAFORO_FLASH_EN.
- Defined:
  - Adds input port flash (1 bit) and parameter T_FLASH (default 8).
  - flash=1 sampled in any state -> FLASH on the next posedge.
  - In FLASH, all phases toggle 010/000 every T_FLASH cycles, starting at 010. pend keeps latching; served stays 0.
  - On flash=0 -> ALLRED for T_ALLRED cycles, then GREEN of phase 0 (fixed mode) or of the first pending phase from 0 (actuated mode).
  - rst overrides flash.
- Undefined: no flash port, no FLASH state, no T_FLASH parameter.

Decomposition:
- Shared package semaforo_pkg:
  - state enum (GREEN, YELLOW, ALLRED, FLASH)
  - light encodings LT_GREEN=3'b100, LT_YELLOW=3'b010, LT_RED=3'b001, LT_OFF=3'b000
- One natural sub-module: semaforo_rr_pick, a combinational round-robin next-pending-phase finder (pend, phase -> next index, valid).

Test Plan:
Common setup for all scenarios: NUM_PH=3, T_GREEN=5, T_YELLOW=2, T_ALLRED=1.
1. Fixed mode, no req, rst released at cycle 0:
   - lights=001_001_100 for cycles 0-4, 001_001_010 for cycles 5-6, 001_001_001 at cycle 7.
   - Cycle 8: 001_100_001 with phase=1. phase 2 follows, then wrap to phase 0 at cycle 24.
2. Fixed mode, req=3'b100 pulsed 1 cycle at cycle 2:
   - pend=100 from cycle 3.
   - served=100 for exactly 1 cycle at cycle 16 (phase 2 first GREEN cycle); pend=000 afterwards.
3. Actuated mode, no req:
   - phase 0 stays green indefinitely with cnt held at 5.
   - Assert req[2] at cycle 20: YELLOW at cycle 22, ALLRED at 24, phase=2 green at 25 (phase 1 skipped), served=100.
4. Actuated mode, req[0] asserted while phase 0 green: pend stays 000 and no served pulse occurs.
5. rst asserted for 1 cycle mid-YELLOW of phase 1 with pend=101: next cycle returns to reset values (phase=0, lights=001_001_100, pend=000).
6. (SEMAFORO_FLASH_EN) flash=1 at cycle 3:
   - All phases show 010 for cycles 4-11, then 000 for cycles 12-19.
   - flash=0 at cycle 20: ALLRED at cycle 21, then phase 0 green at cycle 22.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and light encodings for the multi-phase traffic-light controller.
// Enabling SEMAFORO_FLASH_EN adds the FLASH behaviour in semaforo_multi.
package semaforo_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_FLASH  = 2'd3
    } state_t;

    localparam logic [2:0] LT_GREEN  = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_RED    = 3'b001;
    localparam logic [2:0] LT_OFF    = 3'b000;

    // Lamp pattern of the phase that currently owns the sequence.
    function automatic logic [2:0] active_light(input state_t st);
        case (st)
            ST_GREEN:  return LT_GREEN;
            ST_YELLOW: return LT_YELLOW;
            default:   return LT_RED;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_rr_pick.sv
// Combinational round-robin finder: first set bit of pend searching upward
// from base+1 with wrap-around (base itself is checked last).
module semaforo_rr_pick #(
    parameter int NUM_PH = 2,
    parameter int PH_W   = 1
) (
    input  logic [NUM_PH-1:0] pend,
    input  logic [PH_W-1:0]   base,
    output logic [PH_W-1:0]   next_idx,
    output logic              valid
);

    localparam int SUM_W = PH_W + 1;

    logic [SUM_W-1:0]  cand_sum [NUM_PH];
    logic [PH_W-1:0]   cand_idx [NUM_PH];
    logic [NUM_PH-1:0] hit;

    // Candidate gi is the phase (gi+1) positions after base, modulo NUM_PH.
    for (genvar gi = 0; gi < NUM_PH; gi++) begin : g_cand
        assign cand_sum[gi] = {1'b0, base} + SUM_W'(gi + 1);
        assign cand_idx[gi] = (cand_sum[gi] >= SUM_W'(NUM_PH))
                            ? PH_W'(cand_sum[gi] - SUM_W'(NUM_PH))
                            : PH_W'(cand_sum[gi]);
        assign hit[gi] = pend[cand_idx[gi]];
    end

    always_comb begin
        next_idx = base;
        valid    = 1'b0;
        for (int j = NUM_PH - 1; j >= 0; j--) begin
            if (hit[j]) begin
                next_idx = cand_idx[j];
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaforo_multi.sv
// NUM_PH-phase traffic-light controller: GREEN -> YELLOW -> ALLRED per phase,
// fixed or demand-actuated. Define SEMAFORO_FLASH_EN for the flash port/mode.
module semaforo_multi
    import semaforo_pkg::*;
#(
    parameter int NUM_PH   = 2,
    parameter int CNT_W    = 9,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 4,
    parameter int T_ALLRED = 2,
    parameter int ACTUATED = 0,
`ifdef SEMAFORO_FLASH_EN
    parameter int T_FLASH  = 8,
`endif
    localparam int PH_W = (NUM_PH > 1) ? $clog2(NUM_PH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PH-1:0]   req,
`ifdef SEMAFORO_FLASH_EN
    input  logic                flash,
`endif
    output logic [3*NUM_PH-1:0] lights,
    output logic [PH_W-1:0]     phase,
    output logic [NUM_PH-1:0]   served,
    output logic [NUM_PH-1:0]   pend
);

`ifdef SEMAFORO_FLASH_EN
    localparam int T_FLASH_I = T_FLASH;
`else
    localparam int T_FLASH_I = 1;
`endif
    localparam int CNT_MAX = 2**CNT_W - 1;

    if (T_GREEN < 1 || T_GREEN > CNT_MAX || T_YELLOW < 1 || T_YELLOW > CNT_MAX ||
        T_ALLRED < 1 || T_ALLRED > CNT_MAX || T_FLASH_I < 1 || T_FLASH_I > CNT_MAX) begin : g_bad_dwell
        $error("semaforo_multi: dwell time outside 1..2**CNT_W-1");
    end
    if (NUM_PH < 2 || NUM_PH > 8) begin : g_bad_num_ph
        $error("semaforo_multi: NUM_PH must be 2..8");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TG_C    = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] TY_C    = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] TA_C    = CNT_W'(T_ALLRED);
    localparam logic [CNT_W-1:0] TF_C    = CNT_W'(T_FLASH_I);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [PH_W-1:0]     phase_reg, phase_next, phase_inc;
    logic [PH_W-1:0]     pick_base, pick_idx;
    logic                pick_valid;
    logic [NUM_PH-1:0]   pend_reg, pend_next, served_reg, served_next;
    logic [NUM_PH-1:0]   phase_onehot, clear_vec, green_mask;
    logic [3*NUM_PH-1:0] lights_reg, lights_next, lights_rst;
    logic                blink_reg, blink_next;
    logic                from_flash_reg, from_flash_next;
    logic                other_pend, enter_green, flash_req;

`ifdef SEMAFORO_FLASH_EN
    assign flash_req = flash;
`else
    assign flash_req = 1'b0;
`endif

    assign phase_inc    = (phase_reg == PH_W'(NUM_PH - 1)) ? '0 : phase_reg + PH_W'(1);
    assign phase_onehot = NUM_PH'(1) << phase_reg;
    assign other_pend   = |(pend_reg & ~phase_onehot);
    // After flash the search must start at phase 0, i.e. "after" the last phase.
    assign pick_base    = from_flash_reg ? PH_W'(NUM_PH - 1) : phase_reg;

    semaforo_rr_pick #(
        .NUM_PH (NUM_PH),
        .PH_W   (PH_W)
    ) u_pick (
        .pend     (pend_reg),
        .base     (pick_base),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg + CNT_ONE;
        phase_next      = phase_reg;
        blink_next      = blink_reg;
        from_flash_next = from_flash_reg;
        case (state_reg)
            ST_GREEN: begin
                if (cnt_reg >= TG_C) begin
                    if (ACTUATED == 0 || other_pend) begin
                        state_next = ST_YELLOW;
                        cnt_next   = CNT_ONE;
                    end else begin
                        cnt_next = TG_C;  // rest in green
                    end
                end
            end
            ST_YELLOW: begin
                if (cnt_reg >= TY_C) begin
                    state_next = ST_ALLRED;
                    cnt_next   = CNT_ONE;
                end
            end
            ST_ALLRED: begin
                if (cnt_reg >= TA_C) begin
                    state_next      = ST_GREEN;
                    cnt_next        = CNT_ONE;
                    from_flash_next = 1'b0;
                    if (ACTUATED != 0 && pick_valid) begin
                        phase_next = pick_idx;
                    end else if (from_flash_reg) begin
                        phase_next = '0;
                    end else begin
                        phase_next = phase_inc;
                    end
                end
            end
            ST_FLASH: begin
                if (!flash_req) begin
                    state_next      = ST_ALLRED;
                    cnt_next        = CNT_ONE;
                    from_flash_next = 1'b1;
                end else if (cnt_reg >= TF_C) begin
                    cnt_next   = CNT_ONE;
                    blink_next = ~blink_reg;
                end
            end
        endcase
        if (flash_req && state_reg != ST_FLASH) begin
            state_next = ST_FLASH;
            cnt_next   = CNT_ONE;
            blink_next = 1'b1;
        end
    end

    // Demand latch: clear on entry to the phase's green wins over a same-cycle set.
    assign enter_green = (state_next == ST_GREEN) && (state_reg != ST_GREEN);
    assign clear_vec   = enter_green ? (NUM_PH'(1) << phase_next) : '0;
    assign green_mask  = (state_reg == ST_GREEN) ? phase_onehot : '0;

    for (genvar gi = 0; gi < NUM_PH; gi++) begin : g_phase
        logic [2:0] lt;

        assign pend_next[gi]   = (pend_reg[gi] | (req[gi] & ~green_mask[gi])) & ~clear_vec[gi];
        assign served_next[gi] = clear_vec[gi] & pend_reg[gi];

        always_comb begin
            lt = LT_RED;
            if (state_next == ST_FLASH) begin
                lt = blink_next ? LT_YELLOW : LT_OFF;
            end else if (phase_next == PH_W'(gi)) begin
                lt = active_light(state_next);
            end
        end

        assign lights_next[3*gi +: 3] = lt;
        assign lights_rst[3*gi +: 3]  = (gi == 0) ? LT_GREEN : LT_RED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_GREEN;
            cnt_reg        <= CNT_ONE;
            phase_reg      <= '0;
            pend_reg       <= '0;
            served_reg     <= '0;
            lights_reg     <= lights_rst;
            blink_reg      <= 1'b0;
            from_flash_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            phase_reg      <= phase_next;
            pend_reg       <= pend_next;
            served_reg     <= served_next;
            lights_reg     <= lights_next;
            blink_reg      <= blink_next;
            from_flash_reg <= from_flash_next;
        end
    end

    assign lights = lights_reg;
    assign phase  = phase_reg;
    assign served = served_reg;
    assign pend   = pend_reg;

endmodule
